// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave between two masters;
// ownership lasts for the owner's whole cyc, and a watchdog errors out stalled strobes.
`timescale 1ns/1ps
module wishbone_classic_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BUS_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       s0_wb_cyc,
    input  logic                       s0_wb_stb,
    input  logic                       s0_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]   s0_wb_addr,
    input  logic [BUS_WIDTH*8-1:0]     s0_wb_data_i,
    input  logic [BUS_WIDTH-1:0]       s0_wb_sel,
    input  logic [1:0]                 s0_wb_bte,
    input  logic [2:0]                 s0_wb_cti,
    output logic                       s0_wb_ack,
    output logic                       s0_wb_err,
    output logic [BUS_WIDTH*8-1:0]     s0_wb_data_o,

    input  logic                       s1_wb_cyc,
    input  logic                       s1_wb_stb,
    input  logic                       s1_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]   s1_wb_addr,
    input  logic [BUS_WIDTH*8-1:0]     s1_wb_data_i,
    input  logic [BUS_WIDTH-1:0]       s1_wb_sel,
    input  logic [1:0]                 s1_wb_bte,
    input  logic [2:0]                 s1_wb_cti,
    output logic                       s1_wb_ack,
    output logic                       s1_wb_err,
    output logic [BUS_WIDTH*8-1:0]     s1_wb_data_o,

    output logic                       m_wb_cyc,
    output logic                       m_wb_stb,
    output logic                       m_wb_we,
    output logic [ADDRESS_WIDTH-1:0]   m_wb_addr,
    output logic [BUS_WIDTH*8-1:0]     m_wb_data_o,
    output logic [BUS_WIDTH-1:0]       m_wb_sel,
    output logic [1:0]                 m_wb_bte,
    output logic [2:0]                 m_wb_cti,
    input  logic                       m_wb_ack,
    input  logic                       m_wb_err,
    input  logic [BUS_WIDTH*8-1:0]     m_wb_data_i,

    output logic [1:0]                 grant,
    output logic                       timeout
);

    // One-hot encoding so the state register doubles as the grant output.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (s0_wb_cyc && (!s1_wb_cyc || last_q)) begin
                    state_d = GNT0;
                end else if (s1_wb_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: if (!s0_wb_cyc) state_d = s1_wb_cyc ? GNT1 : IDLE;
            GNT1: if (!s1_wb_cyc) state_d = s0_wb_cyc ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
    end

    always_comb begin
        m_wb_cyc     = 1'b0;
        m_wb_stb     = 1'b0;
        m_wb_we      = 1'b0;
        m_wb_addr    = '0;
        m_wb_data_o  = '0;
        m_wb_sel     = '0;
        m_wb_bte     = '0;
        m_wb_cti     = '0;
        s0_wb_ack    = 1'b0;
        s0_wb_err    = 1'b0;
        s0_wb_data_o = '0;
        s1_wb_ack    = 1'b0;
        s1_wb_err    = 1'b0;
        s1_wb_data_o = '0;
        case (state_q)
            GNT0: begin
                m_wb_cyc     = s0_wb_cyc;
                m_wb_stb     = s0_wb_stb & ~timeout_q;
                m_wb_we      = s0_wb_we;
                m_wb_addr    = s0_wb_addr;
                m_wb_data_o  = s0_wb_data_i;
                m_wb_sel     = s0_wb_sel;
                m_wb_bte     = s0_wb_bte;
                m_wb_cti     = s0_wb_cti;
                s0_wb_ack    = m_wb_ack;
                s0_wb_err    = m_wb_err | timeout_q;
                s0_wb_data_o = m_wb_data_i;
            end
            GNT1: begin
                m_wb_cyc     = s1_wb_cyc;
                m_wb_stb     = s1_wb_stb & ~timeout_q;
                m_wb_we      = s1_wb_we;
                m_wb_addr    = s1_wb_addr;
                m_wb_data_o  = s1_wb_data_i;
                m_wb_sel     = s1_wb_sel;
                m_wb_bte     = s1_wb_bte;
                m_wb_cti     = s1_wb_cti;
                s1_wb_ack    = m_wb_ack;
                s1_wb_err    = m_wb_err | timeout_q;
                s1_wb_data_o = m_wb_data_i;
            end
            default: ;
        endcase
    end

    // The pulse fires after TIMEOUT_CYCLES consecutive stalled strobe cycles,
    // and only while ownership is stable so it always lands on the same owner.
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        always_comb begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            if (state_q != IDLE && state_d == state_q &&
                m_wb_stb && !m_wb_ack && !m_wb_err) begin
                if (int'(cnt_q) == TIMEOUT_CYCLES - 1) begin
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end else begin : g_no_wdog
        assign cnt_d     = '0;
        assign timeout_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = state_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Directed bench for wishbone_classic_arbiter with a registered-ack RAM slave model.
`timescale 1ns/1ps
module tb_wishbone_classic_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        s0_cyc, s0_stb, s0_we, s0_ack, s0_err;
    logic [31:0] s0_addr, s0_wdat, s0_rdat;
    logic [3:0]  s0_sel;
    logic        s1_cyc, s1_stb, s1_we, s1_ack, s1_err;
    logic [31:0] s1_addr, s1_wdat, s1_rdat;
    logic [3:0]  s1_sel;
    logic        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_addr, m_wdat, m_rdat;
    logic [3:0]  m_sel;
    logic [1:0]  m_bte;
    logic [2:0]  m_cti;
    logic [1:0]  grant;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    wishbone_classic_arbiter #(
        .ADDRESS_WIDTH(32), .BUS_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_wb_cyc(s0_cyc), .s0_wb_stb(s0_stb), .s0_wb_we(s0_we), .s0_wb_addr(s0_addr),
        .s0_wb_data_i(s0_wdat), .s0_wb_sel(s0_sel), .s0_wb_bte(2'b00), .s0_wb_cti(3'b000),
        .s0_wb_ack(s0_ack), .s0_wb_err(s0_err), .s0_wb_data_o(s0_rdat),
        .s1_wb_cyc(s1_cyc), .s1_wb_stb(s1_stb), .s1_wb_we(s1_we), .s1_wb_addr(s1_addr),
        .s1_wb_data_i(s1_wdat), .s1_wb_sel(s1_sel), .s1_wb_bte(2'b00), .s1_wb_cti(3'b000),
        .s1_wb_ack(s1_ack), .s1_wb_err(s1_err), .s1_wb_data_o(s1_rdat),
        .m_wb_cyc(m_cyc), .m_wb_stb(m_stb), .m_wb_we(m_we), .m_wb_addr(m_addr),
        .m_wb_data_o(m_wdat), .m_wb_sel(m_sel), .m_wb_bte(m_bte), .m_wb_cti(m_cti),
        .m_wb_ack(m_ack), .m_wb_err(m_err), .m_wb_data_i(m_rdat),
        .grant(grant), .timeout(timeout)
    );

    // Slave model: 16-word RAM, registered ack, default word A5A5_000i, word 4 = DEADBEEF.
    logic        sl_rst, ack_en, err_inj, sl_ack;
    logic [31:0] sl_rdata;
    logic [31:0] mem [0:15];
    logic [15:0] written;
    logic [3:0]  idx;
    assign idx   = m_addr[5:2];
    assign m_ack = sl_ack;
    assign m_err = err_inj;
    assign m_rdat = sl_rdata;

    function automatic logic [31:0] cur_word(input logic [3:0] i);
        if (written[i]) return mem[i];
        if (i == 4'd4) return 32'hDEADBEEF;
        return 32'hA5A5_0000 | {28'h0, i};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sl_rst) begin
            sl_ack   <= 1'b0;
            sl_rdata <= 32'h0;
            written  <= 16'h0;
        end else begin
            sl_ack <= m_cyc & m_stb & ~sl_ack & ack_en;
            if (m_cyc & m_stb & ~sl_ack & ack_en) begin
                if (m_we) begin
                    mem[idx]     <= merge(cur_word(idx), m_wdat, m_sel);
                    written[idx] <= 1'b1;
                end
                sl_rdata <= cur_word(idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic cyc, input logic we,
                         input logic [31:0] addr, input logic [31:0] dat);
        if (p == 0) begin
            s0_cyc = cyc; s0_stb = cyc; s0_we = we; s0_addr = addr; s0_wdat = dat; s0_sel = 4'hF;
        end else begin
            s1_cyc = cyc; s1_stb = cyc; s1_we = we; s1_addr = addr; s1_wdat = dat; s1_sel = 4'hF;
        end
    endtask

    // Returns cycles elapsed until port p sees ack or err, or -1 if none within budget.
    task automatic wait_ack(input int p, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (p == 0 ? (s0_ack | s0_err) : (s1_ack | s1_err)) begin
                n = i;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sl_rst = 1'b1;
        tick();
        rst = 1'b0; sl_rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sl_rst = 1'b1; ack_en = 1'b1; err_inj = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        #1;
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_cmp++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin n_bad++; $display("FAIL reset_mcyc: got cyc=%b stb=%b want 0 0", m_cyc, m_stb); end
        n_cmp++; if (m_addr !== 32'h0 || m_wdat !== 32'h0) begin n_bad++; $display("FAIL reset_mbus: got addr=%h dat=%h want 0", m_addr, m_wdat); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_cmp++; if ({s0_ack, s0_err, s1_ack, s1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_acks: got %b want 0000", {s0_ack, s0_err, s1_ack, s1_err}); end
        rst = 1'b0; sl_rst = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        n_cmp++; if (m_cyc !== 1'b0) begin n_bad++; $display("FAIL sr_latency0: got m_cyc=%b want 0", m_cyc); end
        tick(); #1;
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL sr_grant: got %b want 01", grant); end
        n_cmp++; if (m_cyc !== 1'b1 || m_addr !== 32'h10) begin n_bad++; $display("FAIL sr_mbus: got cyc=%b addr=%h want 1 00000010", m_cyc, m_addr); end
        n_cmp++; if (s0_ack !== 1'b0) begin n_bad++; $display("FAIL sr_early_ack: got %b want 0", s0_ack); end
        tick(); #1;
        n_cmp++; if (s0_ack !== 1'b1 || s0_rdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sr_data: got ack=%b dat=%h want 1 deadbeef", s0_ack, s0_rdat); end
        n_cmp++; if (s1_ack !== 1'b0 || s1_rdat !== 32'h0) begin n_bad++; $display("FAIL sr_s1_quiet: got ack=%b dat=%h want 0 0", s1_ack, s1_rdat); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL sr_release: got %b want 00", grant); end
    endtask

    task automatic test_contention();
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        n_cmp++; if (m_cyc !== 1'b0) begin n_bad++; $display("FAIL ct_latency0: got m_cyc=%b want 0", m_cyc); end
        tick(); #1;
        n_cmp++; if (grant !== 2'b01 || m_addr !== 32'h0) begin n_bad++; $display("FAIL ct_first: got grant=%b addr=%h want 01 0", grant, m_addr); end
        tick(); #1;
        n_cmp++; if (s0_ack !== 1'b1 || s0_rdat !== 32'hA5A50000 || s1_ack !== 1'b0) begin n_bad++; $display("FAIL ct_s0_ack: got ack0=%b dat=%h ack1=%b want 1 a5a50000 0", s0_ack, s0_rdat, s1_ack); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b10 || m_cyc !== 1'b1 || m_addr !== 32'h4) begin n_bad++; $display("FAIL ct_handoff: got grant=%b cyc=%b addr=%h want 10 1 4", grant, m_cyc, m_addr); end
        tick(); #1;
        n_cmp++; if (s1_ack !== 1'b1 || s1_rdat !== 32'hA5A50001 || s0_ack !== 1'b0) begin n_bad++; $display("FAIL ct_s1_ack: got ack1=%b dat=%h ack0=%b want 1 a5a50001 0", s1_ack, s1_rdat, s0_ack); end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL ct_idle: got %b want 00", grant); end
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL ct_rr_tie: got %b want 01", grant); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_hold();
        logic [31:0] wd [3];
        int n;
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        drive(0, 1'b1, 1'b1, 32'h0, wd[0]);
        tick();
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ack(0, n);
            n_cmp++; if (n < 0 || s0_err !== 1'b0) begin n_bad++; $display("FAIL hold_wr%0d: got n=%0d err=%b want ack", k, n, s0_err); end
            n_cmp++; if (grant !== 2'b01 || s1_ack !== 1'b0) begin n_bad++; $display("FAIL hold_own%0d: got grant=%b ack1=%b want 01 0", k, grant, s1_ack); end
            if (k < 2) drive(0, 1'b1, 1'b1, 32'(4 * (k + 1)), wd[k+1]);
            else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
        end
        #1;
        n_cmp++; if (grant !== 2'b10 || m_addr !== 32'h8) begin n_bad++; $display("FAIL hold_handoff: got grant=%b addr=%h want 10 8", grant, m_addr); end
        wait_ack(1, n);
        n_cmp++; if (n < 0 || s1_rdat !== 32'h33333333) begin n_bad++; $display("FAIL hold_rb8: got n=%0d dat=%h want 33333333", n, s1_rdat); end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
        wait_ack(0, n);
        n_cmp++; if (n != 2 || s0_rdat !== 32'h22222222) begin n_bad++; $display("FAIL hold_rb4: got n=%0d dat=%h want 2 22222222", n, s0_rdat); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_watchdog();
        int errs = 0, tos = 0, s0errs = 0, first_err = -1, first_to = -1;
        logic stb_at_err = 1'b1;
        ack_en = 1'b0;
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (timeout) begin tos++; if (first_to < 0) first_to = i; end
            if (s0_err) s0errs++;
            if (s1_err) begin
                errs++;
                if (first_err < 0) begin first_err = i; stb_at_err = m_stb; end
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            tick();
        end
        // One arbitration cycle plus 8 stalled strobe cycles.
        n_cmp++; if (errs != 1 || first_err != 9) begin n_bad++; $display("FAIL wd_err: got count=%0d at=%0d want 1 at 9", errs, first_err); end
        n_cmp++; if (tos != 1 || first_to != 9) begin n_bad++; $display("FAIL wd_pulse: got count=%0d at=%0d want 1 at 9", tos, first_to); end
        n_cmp++; if (stb_at_err !== 1'b0) begin n_bad++; $display("FAIL wd_stb_forced: got %b want 0", stb_at_err); end
        n_cmp++; if (s0errs != 0) begin n_bad++; $display("FAIL wd_s0_err: got %0d want 0", s0errs); end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ack_en = 1'b1;
    endtask

    task automatic test_err();
        ack_en = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL err_grant: got %b want 01", grant); end
        err_inj = 1'b1;
        #1;
        n_cmp++; if (s0_err !== 1'b1 || s1_err !== 1'b0 || s0_ack !== 1'b0) begin n_bad++; $display("FAIL err_pass: got err0=%b err1=%b ack0=%b want 1 0 0", s0_err, s1_err, s0_ack); end
        err_inj = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b00 || s1_ack !== 1'b0) begin n_bad++; $display("FAIL err_after: got grant=%b ack1=%b want 00 0", grant, s1_ack); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        tick();
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b10 || m_stb !== 1'b1) begin n_bad++; $display("FAIL rm_grant: got grant=%b stb=%b want 10 1", grant, m_stb); end
        rst = 1'b1;
        tick(); #1;
        n_cmp++; if (grant !== 2'b00 || m_cyc !== 1'b0 || m_stb !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got grant=%b cyc=%b stb=%b want 00 0 0", grant, m_cyc, m_stb); end
        n_cmp++; if (s1_ack !== 1'b0 || s1_rdat !== 32'h0 || timeout !== 1'b0) begin n_bad++; $display("FAIL rm_no_ack: got ack1=%b dat=%h to=%b want 0 0 0", s1_ack, s1_rdat, timeout); end
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        n_cmp++; if (grant !== 2'b00 || s1_ack !== 1'b0) begin n_bad++; $display("FAIL rm_after: got grant=%b ack1=%b want 00 0", grant, s1_ack); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_watchdog();
        test_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running want finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/wishbone_classic_arbiter.md
# wishbone_classic_arbiter

Two-port round-robin arbiter that shares one Wishbone classic slave (typically `wishbone_classic_block_ram`) between two Wishbone classic masters, e.g. a CPU data port and a DMA engine. It grants the downstream bus to one master for the full duration of that master's `cyc`. It routes the slave's ack, err and read data back to the owner only. A watchdog terminates any access the slave fails to acknowledge within a bounded number of cycles.

## Interface
- ADDRESS_WIDTH, 32, address width of all ports
- BUS_WIDTH, 4, data width in bytes
- TIMEOUT_CYCLES, 256, stalled-access limit in cycles; 0 disables the watchdog
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s0_wb_cyc, s0_wb_stb, s0_wb_we  in  1 each  master 0 cycle, strobe, write enable
- s0_wb_addr  in  ADDRESS_WIDTH  master 0 address
- s0_wb_data_i  in  BUS_WIDTH*8  master 0 write data
- s0_wb_sel  in  BUS_WIDTH  master 0 byte selects
- s0_wb_bte  in  2  master 0 burst type
- s0_wb_cti  in  3  master 0 cycle type
- s0_wb_ack, s0_wb_err  out  1 each  master 0 termination
- s0_wb_data_o  out  BUS_WIDTH*8  master 0 read data
- s1_wb_*  same set as s0_wb_*  master 1
- m_wb_cyc, m_wb_stb, m_wb_we  out  1 each  to shared slave
- m_wb_addr  out  ADDRESS_WIDTH  to shared slave
- m_wb_data_o  out  BUS_WIDTH*8  write data to slave
- m_wb_sel  out  BUS_WIDTH  to shared slave
- m_wb_bte  out  2  to shared slave
- m_wb_cti  out  3  to shared slave
- m_wb_ack, m_wb_err  in  1 each  slave termination
- m_wb_data_i  in  BUS_WIDTH*8  slave read data
- grant  out  2  one-hot current owner; 00 when idle
- timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- Registered state: IDLE, GNT0, GNT1. Also `last` (last granted port; reset 1, so port 0 wins first contention) and a watchdog counter of width clogb2(TIMEOUT_CYCLES+1).
- IDLE:
  - Only s0 cyc high → GNT0. Only s1 cyc high → GNT1.
  - Both high → grant the port not equal to `last`.
  - On grant, `last` is updated to the granted port.
- GNTx: held while sx_wb_cyc=1, independent of the other port's requests. On sx_wb_cyc=0:
  - If the other port's cyc=1 → grant the other port directly.
  - Otherwise → IDLE.
- Downstream mux is combinational from state:
  - In GNTx, all m_wb_* outputs equal the owner's signals.
  - In IDLE, all m_wb_* outputs are 0.
- Upstream return path:
  - Owner: sx_wb_ack = m_wb_ack; sx_wb_err = m_wb_err | timeout; sx_wb_data_o = m_wb_data_i.
  - Non-owner: ack=0, err=0, data_o=0.
  - A non-owner's stb is ignored; it simply waits.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle m_wb_stb=1 and m_wb_ack=0 and m_wb_err=0.
  - It clears on ack/err, on stb=0, or on leaving GNTx.
  - When the counter reaches TIMEOUT_CYCLES, `timeout` is registered high for exactly one cycle and the counter clears. During that cycle m_wb_stb is forced 0 and the owner sees err=1.
  - With TIMEOUT_CYCLES=0 the counter and `timeout` stay 0.

## Timing
- Reset values: state IDLE, grant 00, timeout 0, counter 0, last 1. All m_wb_* and sx_wb_ack/err/data_o are 0.
- Arbitration latency is one cycle: cyc rises in cycle N, m_wb_cyc rises in cycle N+1.
- With the block RAM slave (registered ack), ack reaches the owner in cycle N+2.
- Release: owner drops cyc in cycle M → grant changes (or goes idle) at edge M+1. A waiting port drives m_wb_cyc in cycle M+1 with no idle gap.
- Simultaneous ack and cyc drop by the owner is legal; the ack is delivered.
- Slave ack/err arriving in the same cycle as a watchdog pulse: `timeout` still fires. err is still delivered, and ack is passed through unmodified.
- rst mid-transfer: at the next edge all outputs return to reset values and the in-flight access is abandoned with no ack.

## Test plan
- Single read, s0 only, addr 0x10, RAM word 0xDEADBEEF → m_wb_cyc one cycle after s0 cyc; s0_wb_ack with data 0xDEADBEEF; s1 ack/data stay 0; grant=01.
- Contention right after reset: both cyc raised in the same cycle → s0 served first. s1 receives m_wb_cyc the cycle after s0 drops cyc. Next tie → s0 (round-robin), grant sequence 01,10,01.
- Ownership hold: s0 keeps cyc across writes to 0x0, 0x4, 0x8 with sel=4'hF while s1 requests → all three complete for s0 before grant=10; readback confirms the data.
- Watchdog: TIMEOUT_CYCLES=8, slave ack tied 0, s1 strobes → exactly one s1_wb_err and one timeout pulse, 8 cycles after stb; s0 unaffected.
- Slave error passthrough: m_wb_err=1 during s0 access → s0_wb_err=1 the same cycle, s1_wb_err=0.
- Reset mid-access: rst high while GNT1 with stb pending → next cycle grant=00, m_wb_cyc=0, no ack to s1.
